ser_tx: RTL
===========

Name: ser_tx

Overview:
Parallel-to-serial frame transmitter, UART-style. It accepts a WIDTH-bit word over a valid/ready handshake and serialises it LSB-first as start bit, data bits, optional even-parity bit and stop bit, each held for DIV clock cycles. It is the transmit end for the digital test and readout chain built from the standard-cell models, and drives a single-wire serial line that idles high.

Parameters:
- WIDTH, 8, data bits per frame; valid range 1..32.
- DIV, 4, CLK cycles per serial bit; valid range 1..65535.
- PARITY_EN, 0, 1 inserts an even-parity bit between the last data bit and the stop bit.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RESET  input  1  asynchronous, active-low reset.
- DIN  input  WIDTH  parallel word; sampled only on an accept.
- DIN_VALID  input  1  DIN holds a word to send.
- DIN_READY  output  1  transmitter can accept a word; equals (state==IDLE).
- SOUT  output  1  serial line; idles high.
- BUSY  output  1  high while a frame is in progress (state!=IDLE).

Behaviour:
- Reset: RESET low forces these values immediately, without waiting for CLK:
  - state=IDLE, SOUT=1, BUSY=0, DIN_READY=1;
  - shift register and bit/cycle counters cleared.
  - DIN_VALID is ignored while RESET is low. The first accept is possible on the first CLK rising edge after RESET rises.
- Accept: an accept occurs on a rising edge where DIN_VALID=1 and DIN_READY=1.
  - DIN is latched into the shift register and parity = XOR of DIN is latched.
  - state goes to START on the same edge.
  - DIN changes after the accept have no effect on the frame.
- State machine: IDLE -> START -> DATA -> (PARITY if PARITY_EN) -> STOP -> IDLE.
  - Each of START, PARITY and STOP lasts exactly DIV cycles.
  - DATA lasts WIDTH*DIV cycles. The shift register shifts right once per completed bit period, and SOUT = sreg[0].
- SOUT per state: IDLE=1, START=0, DATA=current LSB, PARITY=latched parity, STOP=1.
- SOUT is a registered output (set-type flop) with no combinational path from DIN or DIN_VALID.
- Latency: SOUT falls on the edge that accepts the word. Frame length is (WIDTH+2+PARITY_EN)*DIV cycles from accept to IDLE.
- Cycle counter:
  - width = max(1, clog2(DIV)); counts 0..DIV-1.
  - The terminal count (DIV-1) advances the bit.
  - For DIV=1, every cycle is terminal.
- Bit counter:
  - width = clog2(WIDTH+1); counts data bits 0..WIDTH-1.
  - The terminal count with cycle terminal moves DATA to PARITY or STOP.
- Back-to-back frames:
  - The STOP terminal edge returns to IDLE, and DIN_READY=1 in the following cycle.
  - With DIN_VALID held high, the next accept occurs on the next edge. The line therefore gives exactly DIV+1 high cycles between frames (stop bit plus one IDLE cycle).
- DIN_VALID while busy: ignored. No queuing and no error flag; the upstream holds the word until it sees DIN_READY.
- Reset mid-frame: the frame aborts, SOUT returns to 1 asynchronously, and no partial retransmission follows after RESET rises.
- Counters never wrap past their terminal values; any other encoding falls back to IDLE on the next edge.

Decomposition:
- Package ser_tx_pkg:
  - state encoding constants ST_IDLE=0, ST_START=1, ST_DATA=2, ST_PARITY=3, ST_STOP=4 (3-bit);
  - the clog2 width helper.
- Sub-module ser_tx_baud: DIV-cycle counter.
  - Ports: CLK, RESET, CLR, TICK.
  - CLR restarts the count; TICK is high on the terminal count.
  - The FSM asserts CLR on accept.

Test Plan:
1. Reset and idle: RESET low mid-clock, then released with DIN_VALID=0 for 20 cycles -> SOUT=1, BUSY=0, DIN_READY=1 throughout, including before the first CLK edge.
2. Single frame, WIDTH=8, DIV=4, PARITY_EN=0, DIN=8'hA5 -> SOUT bit sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles. BUSY is high for 40 cycles, and DIN_READY returns high on cycle 41.
3. Parity, PARITY_EN=1, DIN=8'h07 (three ones) -> 11-bit frame 0,1,1,1,0,0,0,0,0,1(parity),1 (44 cycles); DIN=8'h03 gives parity bit 0.
4. Back-to-back, DIN_VALID held high with 8'hFF then 8'h00, DIV=4 -> the second start bit falls exactly 5 cycles after the first stop bit begins; both frames are correct.
5. Busy-time valid, DIN_VALID pulsed with 8'h3C during DATA of an 8'h81 frame -> the 8'h81 frame is unaffected and 8'h3C is never transmitted.
6. Mid-frame reset during data bit 3, then DIV=1 frame with 8'h5A -> SOUT goes high asynchronously and no residual bits appear. After release, DIV=1 gives a 10-cycle frame of 0,0,1,0,1,1,0,1,0,1.

Source files
------------

// File: rtl/ser_tx_pkg.sv
// Shared definitions for the ser_tx serial transmitter: FSM state
// encoding and the counter-width helper used by the top and the baud counter.
package ser_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // Number of bits needed to hold values 0..value-1, never less than 1.
  function automatic int clog2_w(input int value);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'sd1 << i) < value) begin
        w = i + 1;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/ser_tx_baud.sv
// Bit-period timer for ser_tx: counts 0..DIV-1 and flags the last cycle of
// each serial bit. CLR restarts the period so a new frame starts aligned.
module ser_tx_baud
  import ser_tx_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic CLK,
  input  logic RESET,
  input  logic CLR,
  output logic TICK
);

  localparam int CW = clog2_w(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_r;

  // Terminal count marks the final cycle of a bit period (every cycle when DIV=1).
  assign TICK = (cnt_r == LAST);

  // Cycle counter: restart on CLR or after the terminal count, otherwise advance.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt_r <= '0;
    end else if (CLR || TICK) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

endmodule

// File: rtl/ser_tx.sv
// UART-style parallel-to-serial transmitter. Accepts a WIDTH-bit word over
// valid/ready and sends start, LSB-first data, optional even parity and stop,
// each held DIV cycles. All outputs come straight from flops.
module ser_tx
  import ser_tx_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DIV       = 4,
  parameter bit PARITY_EN = 1'b0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] DIN,
  input  logic             DIN_VALID,
  output logic             DIN_READY,
  output logic             SOUT,
  output logic             BUSY
);

  localparam int BW = clog2_w(WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  state_t           state_r;
  logic [WIDTH-1:0] sreg_r;
  logic [WIDTH-1:0] sreg_shift_s;
  logic             par_r;
  logic [BW-1:0]    bit_cnt_r;
  logic             sout_r;
  logic             busy_r;
  logic             ready_r;
  logic             accept_s;
  logic             tick_s;

  // ready_r mirrors state_r==ST_IDLE, so accept needs no state decode.
  assign accept_s     = DIN_VALID & ready_r;
  assign sreg_shift_s = sreg_r >> 1;

  assign DIN_READY = ready_r;
  assign SOUT      = sout_r;
  assign BUSY      = busy_r;

  ser_tx_baud #(
    .DIV (DIV)
  ) u_baud (
    .CLK   (CLK),
    .RESET (RESET),
    .CLR   (accept_s),
    .TICK  (tick_s)
  );

  // Frame sequencer: next state and next line level are decided together so SOUT is a plain flop.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_r   <= ST_IDLE;
      sreg_r    <= '0;
      par_r     <= 1'b0;
      bit_cnt_r <= '0;
      sout_r    <= 1'b1;
      busy_r    <= 1'b0;
      ready_r   <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            sreg_r    <= DIN;
            par_r     <= ^DIN;
            bit_cnt_r <= '0;
            state_r   <= ST_START;
            sout_r    <= 1'b0;
            busy_r    <= 1'b1;
            ready_r   <= 1'b0;
          end else begin
            sout_r  <= 1'b1;
            busy_r  <= 1'b0;
            ready_r <= 1'b1;
          end
        end
        ST_START: begin
          if (tick_s) begin
            state_r <= ST_DATA;
            sout_r  <= sreg_r[0];
          end
        end
        ST_DATA: begin
          if (tick_s) begin
            if (bit_cnt_r == LAST_BIT) begin
              if (PARITY_EN) begin
                state_r <= ST_PARITY;
                sout_r  <= par_r;
              end else begin
                state_r <= ST_STOP;
                sout_r  <= 1'b1;
              end
            end else begin
              sreg_r    <= sreg_shift_s;
              bit_cnt_r <= bit_cnt_r + BW'(1);
              sout_r    <= sreg_shift_s[0];
            end
          end
        end
        ST_PARITY: begin
          if (tick_s) begin
            state_r <= ST_STOP;
            sout_r  <= 1'b1;
          end
        end
        ST_STOP: begin
          if (tick_s) begin
            state_r <= ST_IDLE;
            sout_r  <= 1'b1;
            busy_r  <= 1'b0;
            ready_r <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          sout_r  <= 1'b1;
          busy_r  <= 1'b0;
          ready_r <= 1'b1;
        end
      endcase
    end
  end

endmodule
